// File: rtl/heartbeat_tone_seq.sv
// Heartbeat "lub-dub" sequencer: on each accepted beat it drives the tone
// divider's period select through LUB tone, silent gap, DUB tone, then silence.
module heartbeat_tone_seq #(
  parameter int unsigned clk_freq = 12_000_000,
  parameter int unsigned LUB_MS   = 100,
  parameter int unsigned GAP_MS   = 80,
  parameter int unsigned DUB_MS   = 120,
  parameter logic [3:0]  LUB_CODE = 4'd2,
  parameter logic [3:0]  DUB_CODE = 4'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       beat,
  output logic [3:0] period,
  output logic       busy,
  output logic       done
);

  localparam int unsigned TICKS_PER_MS = clk_freq / 1000;
  localparam int unsigned MS_MAX_LG = (LUB_MS > GAP_MS) ? LUB_MS : GAP_MS;
  localparam int unsigned MS_MAX    = (MS_MAX_LG > DUB_MS) ? MS_MAX_LG : DUB_MS;
  localparam int unsigned PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int unsigned MW = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;

  if (clk_freq < 1000 || (clk_freq % 1000) != 0) begin : g_bad_clk_freq
    $error("heartbeat_tone_seq: clk_freq must be a nonzero multiple of 1000");
  end
  if (LUB_MS < 1 || GAP_MS < 1 || DUB_MS < 1) begin : g_bad_durations
    $error("heartbeat_tone_seq: LUB_MS, GAP_MS and DUB_MS must be >= 1");
  end
  if (LUB_CODE < 4'd1 || LUB_CODE > 4'd4 || DUB_CODE < 4'd1 || DUB_CODE > 4'd4)
  begin : g_bad_codes
    $error("heartbeat_tone_seq: LUB_CODE and DUB_CODE must be in 1..4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LUB  = 2'd1,
    GAP  = 2'd2,
    DUB  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [MW-1:0]   ms_q, ms_d;
  logic [3:0]      period_q, period_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ms_tick;
  logic            state_end;
  logic [MW-1:0]   ms_last;

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    ms_d      = ms_q;
    done_d    = 1'b0;
    ms_last   = '0;
    ms_tick   = (presc_q == PW'(TICKS_PER_MS - 1));

    // Only the active state's duration is relevant to the terminal compare.
    case (state_q)
      LUB:     ms_last = MW'(LUB_MS - 1);
      GAP:     ms_last = MW'(GAP_MS - 1);
      DUB:     ms_last = MW'(DUB_MS - 1);
      default: ms_last = '0;
    endcase
    state_end = ms_tick && (ms_q == ms_last);

    case (state_q)
      IDLE: if (beat && enable) state_d = LUB;
      LUB: begin
        if (!enable)        state_d = IDLE;
        else if (state_end) state_d = GAP;
      end
      GAP: begin
        if (!enable)        state_d = IDLE;
        else if (state_end) state_d = DUB;
      end
      DUB: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (state_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Counters restart on every state change so each state gets its full span.
    if (state_d != state_q || state_q == IDLE) begin
      presc_d = '0;
      ms_d    = '0;
    end else if (ms_tick) begin
      presc_d = '0;
      ms_d    = ms_q + 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end

    case (state_d)
      LUB:     period_d = LUB_CODE;
      DUB:     period_d = DUB_CODE;
      default: period_d = 4'd0;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      ms_q     <= '0;
      period_q <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      ms_q     <= ms_d;
      period_q <= period_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign period = period_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
